// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: padder FSM states, padding constants and the round constant table.
package sha256_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, EMIT, DONE} pad_state_e;

    localparam logic [31:0] SHA256_PAD_WORD = 32'h8000_0000;
    localparam int unsigned BLOCK_WORDS     = 16;

    // Marker word plus 64-bit length must fit after the message, hence the +2.
    function automatic int unsigned num_pad_blocks(int unsigned words);
        return (words + 2) / BLOCK_WORDS + 1;
    endfunction

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

endpackage

// File: rtl/sha256_pad_word_sel.sv
// Decides what a block slot holds: a memory word, or a constant (pad marker, length, zero).
module sha256_pad_word_sel
    import sha256_pkg::*;
#(
    parameter int unsigned NUM_OF_WORDS = 20
) (
    input  logic [11:0] g,
    input  logic        blk_last,
    input  logic [3:0]  slot,
    input  logic [63:0] msg_len,
    output logic        src_mem,
    output logic [31:0] const_word
);

    always_comb begin
        src_mem    = 1'b0;
        const_word = '0;
        if (g < 12'(NUM_OF_WORDS)) begin
            src_mem = 1'b1;
        end else if (g == 12'(NUM_OF_WORDS)) begin
            const_word = SHA256_PAD_WORD;
        end else if (blk_last && slot == 4'd14) begin
            const_word = msg_len[63:32];
        end else if (blk_last && slot == 4'd15) begin
            const_word = msg_len[31:0];
        end
    end

endmodule

// File: rtl/sha256_msg_padder.sv
// Fetches a message from word memory and emits SHA-256 padded 512-bit blocks over valid/ready.
// Define SHA256_PAD_BSWAP_EN to byte-reverse each fetched memory word (little-endian images).
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter int unsigned NUM_OF_WORDS = 20,
    parameter int unsigned MEM_LAT      = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [15:0]  message_addr,
    output logic         mem_clk,
    output logic         mem_we,
    output logic [15:0]  mem_addr,
    input  logic [31:0]  mem_read_data,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [511:0] blk_data,
    output logic         blk_last,
    output logic [7:0]   blk_idx,
    output logic         busy,
    output logic         done
);

    localparam int unsigned NB       = num_pad_blocks(NUM_OF_WORDS);
    localparam logic [7:0]  LAST_IDX = 8'(NB - 1);
    localparam logic [63:0] MSG_LEN  = 64'(NUM_OF_WORDS) * 64'd32;

    pad_state_e             state_q, state_d;
    logic [15:0]            base_q, base_d;
    logic [7:0]             blk_idx_q, blk_idx_d;
    logic [3:0]             slot_q, slot_d;
    logic                   issued_all_q, issued_all_d;
    logic [MEM_LAT-1:0]     pipe_vld_q, pipe_vld_d;
    logic [MEM_LAT-1:0][3:0] pipe_slot_q, pipe_slot_d;
    logic [15:0][31:0]      buf_q, buf_d;

    logic        issue, mem_issue, src_mem, pending, all_issued_next, is_last;
    logic [31:0] const_word, rd_word;

    assign is_last         = (blk_idx_q == LAST_IDX);
    assign issue           = (state_q == FETCH) && !issued_all_q;
    assign mem_issue       = issue && src_mem;
    assign all_issued_next = issued_all_q || (issue && slot_q == 4'd15);

    sha256_pad_word_sel #(
        .NUM_OF_WORDS (NUM_OF_WORDS)
    ) u_word_sel (
        .g          ({blk_idx_q, slot_q}),
        .blk_last   (is_last),
        .slot       (slot_q),
        .msg_len    (MSG_LEN),
        .src_mem    (src_mem),
        .const_word (const_word)
    );

`ifdef SHA256_PAD_BSWAP_EN
    assign rd_word = {mem_read_data[7:0], mem_read_data[15:8],
                      mem_read_data[23:16], mem_read_data[31:24]};
`else
    assign rd_word = mem_read_data;
`endif

    // Read tags travel alongside the memory latency; the last stage marks data landing now.
    always_comb begin
        pipe_vld_d  = pipe_vld_q;
        pipe_slot_d = pipe_slot_q;
        pending     = mem_issue;
        for (int i = int'(MEM_LAT) - 1; i > 0; i--) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_slot_d[i] = pipe_slot_q[i-1];
        end
        pipe_vld_d[0]  = mem_issue;
        pipe_slot_d[0] = slot_q;
        for (int i = 0; i < int'(MEM_LAT) - 1; i++) begin
            pending = pending | pipe_vld_q[i];
        end
    end

    // Slot 0 lives in the top word so blk_data needs no reordering.
    always_comb begin
        buf_d = buf_q;
        if (pipe_vld_q[MEM_LAT-1]) begin
            buf_d[4'd15 - pipe_slot_q[MEM_LAT-1]] = rd_word;
        end
        if (issue && !src_mem) begin
            buf_d[4'd15 - slot_q] = const_word;
        end
    end

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        blk_idx_d    = blk_idx_q;
        slot_d       = slot_q;
        issued_all_d = issued_all_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    base_d       = message_addr;
                    blk_idx_d    = '0;
                    slot_d       = '0;
                    issued_all_d = 1'b0;
                    state_d      = FETCH;
                end
            end
            FETCH: begin
                if (issue) begin
                    slot_d       = slot_q + 4'd1;
                    issued_all_d = all_issued_next;
                end
                // Pad slots can finish before outstanding reads, so wait for the pipe to drain.
                if (all_issued_next && !pending) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (blk_ready) begin
                    if (is_last) begin
                        state_d = DONE;
                    end else begin
                        blk_idx_d    = blk_idx_q + 8'd1;
                        slot_d       = '0;
                        issued_all_d = 1'b0;
                        state_d      = FETCH;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            base_q       <= '0;
            blk_idx_q    <= '0;
            slot_q       <= '0;
            issued_all_q <= 1'b0;
            pipe_vld_q   <= '0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            blk_idx_q    <= blk_idx_d;
            slot_q       <= slot_d;
            issued_all_q <= issued_all_d;
            pipe_vld_q   <= pipe_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        pipe_slot_q <= pipe_slot_d;
        buf_q       <= buf_d;
    end

    assign mem_clk   = clk;
    assign mem_we    = 1'b0;
    assign mem_addr  = mem_issue ? (base_q + 16'({blk_idx_q, slot_q})) : 16'h0000;
    assign blk_valid = (state_q == EMIT);
    assign blk_last  = (state_q == EMIT) && is_last;
    assign blk_idx   = blk_idx_q;
    assign blk_data  = buf_q;
    assign busy      = (state_q == FETCH) || (state_q == EMIT);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Scoreboard bench for sha256_msg_padder: three message lengths, backpressure, reset, wrap.
module tb_sha256_msg_padder;

    typedef struct packed {
        logic [511:0] data;
        logic         last;
        logic [7:0]   idx;
    } blk_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    blk_t q20[$];
    blk_t q13[$];
    blk_t q14[$];
    int done20 = 0;
    int done13 = 0;
    int done14 = 0;

    logic         s20, s13, s14, rdy20, rdy13, rdy14;
    logic [15:0]  a20, a13, a14, ma20, ma13, ma14;
    logic         mc20, mc13, mc14, we20, we13, we14;
    logic [31:0]  rd20, rd13, rd14;
    logic         v20, v13, v14, l20, l13, l14;
    logic [511:0] d20, d13, d14;
    logic [7:0]   i20, i13, i14;
    logic         b20, b13, b14, dn20, dn13, dn14;

    sha256_msg_padder #(.NUM_OF_WORDS(20), .MEM_LAT(1)) u_dut20 (
        .clk(clk), .reset(reset), .start(s20), .message_addr(a20), .mem_clk(mc20),
        .mem_we(we20), .mem_addr(ma20), .mem_read_data(rd20), .blk_valid(v20),
        .blk_ready(rdy20), .blk_data(d20), .blk_last(l20), .blk_idx(i20), .busy(b20),
        .done(dn20)
    );
    sha256_msg_padder #(.NUM_OF_WORDS(13), .MEM_LAT(1)) u_dut13 (
        .clk(clk), .reset(reset), .start(s13), .message_addr(a13), .mem_clk(mc13),
        .mem_we(we13), .mem_addr(ma13), .mem_read_data(rd13), .blk_valid(v13),
        .blk_ready(rdy13), .blk_data(d13), .blk_last(l13), .blk_idx(i13), .busy(b13),
        .done(dn13)
    );
    sha256_msg_padder #(.NUM_OF_WORDS(14), .MEM_LAT(1)) u_dut14 (
        .clk(clk), .reset(reset), .start(s14), .message_addr(a14), .mem_clk(mc14),
        .mem_we(we14), .mem_addr(ma14), .mem_read_data(rd14), .blk_valid(v14),
        .blk_ready(rdy14), .blk_data(d14), .blk_last(l14), .blk_idx(i14), .busy(b14),
        .done(dn14)
    );

    function automatic logic [31:0] word_at(logic [15:0] a);
        if (a == 16'hFFF8) return 32'h11223344;
        if (a >= 16'h0100 && a < 16'h0500) return 32'(a - 16'h0100) + 32'd1;
        return {a ^ 16'h5A5A, a};
    endfunction

    function automatic logic [31:0] exp_mem(logic [15:0] a);
        logic [31:0] w;
        w = word_at(a);
`ifdef SHA256_PAD_BSWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    function automatic blk_t exp_block(int nw, logic [15:0] base, int b);
        blk_t r;
        int nb;
        int g;
        logic [63:0] len;
        logic [31:0] w;
        nb = (nw + 2) / 16 + 1;
        len = 64'(nw) * 64'd32;
        r.last = (b == nb - 1);
        r.idx = 8'(b);
        r.data = '0;
        for (int s = 0; s < 16; s++) begin
            g = b * 16 + s;
            if (g < nw) w = exp_mem(base + 16'(g));
            else if (g == nw) w = 32'h8000_0000;
            else if (r.last && s == 14) w = len[63:32];
            else if (r.last && s == 15) w = len[31:0];
            else w = 32'h0;
            r.data[511 - 32 * s -: 32] = w;
        end
        return r;
    endfunction

    // Synchronous read memories, one cycle of latency.
    always @(posedge clk) begin
        rd20 <= word_at(ma20);
        rd13 <= word_at(ma13);
        rd14 <= word_at(ma14);
    end

    task automatic check(string tag, logic [511:0] got, logic [511:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push20(logic [15:0] base);
        for (int b = 0; b < 2; b++) q20.push_back(exp_block(20, base, b));
    endtask

    task automatic start20(logic [15:0] base);
        push20(base);
        a20 = base;
        s20 = 1'b1;
        @(posedge clk);
        #1 s20 = 1'b0;
    endtask

    task automatic wait_done20(int budget);
        int c;
        int d0;
        c = 0;
        d0 = done20;
        while (done20 == d0 && c < budget) begin
            @(posedge clk);
            c++;
        end
        check("u20 done reached", done20 - d0, 1);
        #1;
    endtask

    logic xl20 = 1'b0;
    logic xl13 = 1'b0;
    logic xl14 = 1'b0;

    always @(negedge clk) begin
        blk_t e;
        if (!reset && v20 && rdy20) begin
            check("u20 block expected", q20.size() != 0, 1);
            if (q20.size() != 0) begin
                e = q20.pop_front();
                check("u20 data", d20, e.data);
                check("u20 last", l20, e.last);
                check("u20 idx", i20, e.idx);
            end
        end
        if (!reset && v13 && rdy13) begin
            check("u13 block expected", q13.size() != 0, 1);
            if (q13.size() != 0) begin
                e = q13.pop_front();
                check("u13 data", d13, e.data);
                check("u13 last", l13, e.last);
                check("u13 idx", i13, e.idx);
            end
        end
        if (!reset && v14 && rdy14) begin
            check("u14 block expected", q14.size() != 0, 1);
            if (q14.size() != 0) begin
                e = q14.pop_front();
                check("u14 data", d14, e.data);
                check("u14 last", l14, e.last);
                check("u14 idx", i14, e.idx);
            end
        end
        if (dn20 || xl20) check("u20 done one cycle after last transfer", dn20, xl20);
        if (dn13 || xl13) check("u13 done one cycle after last transfer", dn13, xl13);
        if (dn14 || xl14) check("u14 done one cycle after last transfer", dn14, xl14);
        if (dn20) done20++;
        if (dn13) done13++;
        if (dn14) done14++;
        xl20 = !reset && v20 && rdy20 && l20;
        xl13 = !reset && v13 && rdy13 && l13;
        xl14 = !reset && v14 && rdy14 && l14;
    end

    initial begin
        int cnt;
        blk_t eb;
        s20 = 0; s13 = 0; s14 = 0;
        a20 = 0; a13 = 0; a14 = 0;
        rdy20 = 1; rdy13 = 1; rdy14 = 1;
        reset = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset blk_valid", v20, 0);
        check("reset blk_last", l20, 0);
        check("reset blk_idx", i20, 0);
        check("reset busy", b20, 0);
        check("reset done", dn20, 0);
        check("reset mem_addr", ma20, 0);
        check("mem_we", we20, 0);
        @(posedge clk);
        #1 reset = 0;

        // 20 words at 0x100 with ready tied high, plus first-block latency
        start20(16'h0100);
        check("busy after start", b20, 1);
        cnt = 0;
        while (!v20 && cnt < 40) begin
            @(posedge clk);
            #1 cnt++;
        end
        check("first blk_valid latency", cnt, 17);
        wait_done20(200);
        check("busy after done", b20, 0);

        // 13 and 14 word messages, single and double block edge cases
        for (int b = 0; b < 1; b++) q13.push_back(exp_block(13, 16'h0100, b));
        for (int b = 0; b < 2; b++) q14.push_back(exp_block(14, 16'h0300, b));
        a13 = 16'h0100; a14 = 16'h0300; s13 = 1; s14 = 1;
        @(posedge clk);
        #1 s13 = 0; s14 = 0;
        cnt = 0;
        while ((done13 == 0 || done14 == 0) && cnt < 200) begin
            @(posedge clk);
            cnt++;
        end
        check("u13 done count", done13, 1);
        check("u14 done count", done14, 1);

        // Backpressure with an ignored start during EMIT
        rdy20 = 0;
        start20(16'h0100);
        cnt = 0;
        while (!v20 && cnt < 40) begin
            @(posedge clk);
            #1 cnt++;
        end
        eb = exp_block(20, 16'h0100, 0);
        s20 = 1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1 s20 = 0;
            check("stall blk_valid", v20, 1);
            check("stall blk_data", d20, eb.data);
            check("stall blk_idx", i20, 0);
        end
        rdy20 = 1;
        @(posedge clk);
        #1 rdy20 = 0;
        check("after release blk_valid", v20, 0);
        check("after release blk_idx", i20, 1);
        rdy20 = 1;
        wait_done20(200);

        // Reset in the middle of fetching block 1, then restart at 0x200
        start20(16'h0100);
        cnt = 0;
        while (i20 != 8'd1 && cnt < 60) begin
            @(posedge clk);
            #1 cnt++;
        end
        check("reached block 1", i20, 1);
        repeat (3) @(posedge clk);
        #1 reset = 1;
        @(posedge clk);
        #1;
        check("mid reset blk_valid", v20, 0);
        check("mid reset blk_last", l20, 0);
        check("mid reset blk_idx", i20, 0);
        check("mid reset busy", b20, 0);
        check("mid reset done", dn20, 0);
        check("mid reset mem_addr", ma20, 0);
        reset = 0;
        q20.delete();
        start20(16'h0200);
        check("restart mem_addr", ma20, 16'h0200);
        check("restart blk_idx", i20, 0);
        wait_done20(200);

        // Address wrap across 0xFFFF
        start20(16'hFFF8);
        check("wrap first mem_addr", ma20, 16'hFFF8);
        wait_done20(200);

        check("u20 queue drained", q20.size(), 0);
        check("u13 queue drained", q13.size(), 0);
        check("u14 queue drained", q14.size(), 0);
        check("u20 total done pulses", done20, 4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sha256_msg_padder.md
Name: sha256_msg_padder

Overview:
- Upstream feeder for the SHA-256 hash core.
- Fetches NUM_OF_WORDS 32-bit message words from shared word-addressed memory starting at message_addr.
- Applies standard SHA-256 padding: 0x80000000 marker word, zero fill, 64-bit bit-length trailer.
- Emits one 512-bit block at a time over a valid/ready handshake, so the hash core only performs compression.

Parameters:
- NUM_OF_WORDS, 20, message length in 32-bit words (1..1024).
- MEM_LAT, 1, cycles from mem_addr presented to mem_read_data valid (1..3).

Ports:
- clk  input  1  clock; also drives mem_clk.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; sampled in IDLE only.
- message_addr  input  16  word address of message word 0; captured on accepted start.
- mem_clk  output  1  equals clk.
- mem_we  output  1  constant 0 (read-only block).
- mem_addr  output  16  read address.
- mem_read_data  input  32  read data.
- blk_valid  output  1  blk_data holds a complete padded block.
- blk_ready  input  1  consumer accepts the block.
- blk_data  output  512  word 0 in [511:480], word 15 in [31:0].
- blk_last  output  1  qualifies the final block of the message.
- blk_idx  output  8  block number, from 0.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse after the last block is accepted.

Behaviour:
- Reset (synchronous, active-high) from any state, including mid-fetch or mid-handshake:
  - state IDLE; blk_valid=0, blk_last=0, blk_idx=0, busy=0, done=0, mem_addr=0.
  - Buffer contents are don't-care.
- Block count: NB = (NUM_OF_WORDS+2)/16 + 1, integer division, computed at elaboration. L = NUM_OF_WORDS*32 bits, a 64-bit constant.
- Global word index g = blk_idx*16 + slot selects the content of each slot:
  - g < NUM_OF_WORDS: memory word at message_addr+g.
  - g == NUM_OF_WORDS: 0x80000000.
  - last block, slot 14: L[63:32].
  - last block, slot 15: L[31:0].
  - otherwise: 0.
- Address wrap: message_addr+g wraps modulo 2^16.
- States:
  - IDLE: busy=0. On start, capture message_addr, go to FETCH; blk_idx=0, slot=0.
  - FETCH: one slot per cycle.
    - Memory slots: issue address, store data MEM_LAT cycles later, pipelined so one word lands per cycle after the initial latency.
    - Pad slots: no memory read; constant written in 1 cycle.
    - When slot 15 is written, go to EMIT.
  - EMIT: blk_valid=1; blk_last=(blk_idx==NB-1).
    - blk_data, blk_last, blk_idx stay stable until the cycle with blk_valid && blk_ready; that edge is the transfer.
    - On transfer, not last: blk_idx++, go to FETCH. Last: go to DONE.
    - blk_valid never drops without a transfer.
  - DONE: done=1 for one cycle, go to IDLE.
- start while busy is ignored. blk_ready outside EMIT is ignored.
- Latency, NUM_OF_WORDS=20, MEM_LAT=1, blk_ready tied high:
  - First blk_valid 17 cycles after the start edge.
  - done 1 cycle after the last transfer.

Optional Feature:
- Macro: SHA256_PAD_BSWAP_EN.
- Defined: each memory word is byte-reversed before storage (0x11223344 becomes 0x44332211), for little-endian message images. Pad and length words are not swapped.
- Undefined: words are stored unchanged.

Decomposition:
- sha256_pkg holds:
  - the padder state enum {IDLE, FETCH, EMIT, DONE};
  - SHA256_PAD_WORD = 32'h80000000;
  - BLOCK_WORDS = 16;
  - function num_pad_blocks(words);
  - the existing K constant table.
- One sub-module, sha256_pad_word_sel: combinational slot-content selector taking g, blk_last, slot and L, returning the source select and the constant word. The padder instantiates it once.

Test Plan:
- NUM_OF_WORDS=20, mem[0x100+n]=n+1, message_addr=0x100, blk_ready=1:
  - block0 words = 1..16, blk_last=0.
  - block1 words0-3 = 17..20, word4=0x80000000, words5-14=0, word15=0x00000280, blk_last=1.
  - done pulses once.
- NUM_OF_WORDS=13: single block; words13-15 = 0x80000000, 0, 0x000001A0; blk_last=1 on block 0.
- NUM_OF_WORDS=14: two blocks.
  - block0 word14=0x80000000, word15=0.
  - block1 words0-14=0, word15=0x000001C0.
- Backpressure: hold blk_ready=0 for 5 cycles in EMIT -> blk_valid stays 1 and blk_data/blk_idx unchanged. Release -> exactly one transfer, blk_idx increments.
- Reset pulsed mid-FETCH of block 1 -> next cycle IDLE, all outputs at reset values. New start at 0x200 restarts at blk_idx=0 with reads from 0x200. start pulsed during EMIT is ignored.
- message_addr=0xFFF8, NUM_OF_WORDS=20 -> reads wrap 0xFFF8..0xFFFF, 0x0000..0x000B. With SHA256_PAD_BSWAP_EN, mem word 0x11223344 appears as 0x44332211; pad and length words are unchanged.
